traffic_intersection_ctrl: RTL and testbench

Two-road intersection controller: main road (NS) and side road (EW). NS rests in green; EW gets a green only when a vehicle sensor or pedestrian request is latched. Phase durations are parametrised. Adds all-red clearance, a pedestrian walk signal and a flashing night/fault mode. Sits beside the single-light controller and drives two signal heads plus a walk lamp.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/phase_timer.sv | 33 +++
 rtl/traffic_intersection_ctrl.sv | 139 +++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// traffic_pkg : light/phase encodings and per-phase duration lookup
// Rev 1.0
// ----------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10,
    OFF    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } phase_t;

  // FLASH maps to the blink half-period; the timer reloads with it each half.
  function automatic int unsigned phase_duration(
    input phase_t      p,
    input int unsigned ns_min_green,
    input int unsigned ew_green,
    input int unsigned yellow_time,
    input int unsigned allred_time,
    input int unsigned flash_half
  );
    case (p)
      NS_GREEN:             phase_duration = ns_min_green;
      NS_YELLOW, EW_YELLOW: phase_duration = yellow_time;
      EW_GREEN:             phase_duration = ew_green;
      FLASH:                phase_duration = flash_half;
      default:              phase_duration = allred_time;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ----------------------------------------------------------------------
// phase_timer : loadable down-counter that saturates at zero
// Rev 1.0
// ----------------------------------------------------------------------
module phase_timer #(
  parameter int unsigned       TIME_W    = 8,
  parameter logic [TIME_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic              zero
);

  logic [TIME_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TIME_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// traffic_intersection_ctrl : NS/EW intersection with all-red, walk, flash
// Rev 1.0
// ----------------------------------------------------------------------
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TIME_W       = 8,
  parameter int unsigned NS_MIN_GREEN = 8,
  parameter int unsigned EW_GREEN     = 5,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALLRED_TIME  = 1,
  parameter int unsigned FLASH_HALF   = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   ew_sensor,
  input  logic   ped_req,
  input  logic   flash_mode,
  output light_t ns_light,
  output light_t ew_light,
  output logic   walk,
  output phase_t phase
);

  generate
    if ((TIME_W == 0) ||
        (NS_MIN_GREEN == 0) || ((NS_MIN_GREEN >> TIME_W) != 0) ||
        (EW_GREEN     == 0) || ((EW_GREEN     >> TIME_W) != 0) ||
        (YELLOW_TIME  == 0) || ((YELLOW_TIME  >> TIME_W) != 0) ||
        (ALLRED_TIME  == 0) || ((ALLRED_TIME  >> TIME_W) != 0) ||
        (FLASH_HALF   == 0) || ((FLASH_HALF   >> TIME_W) != 0)) begin : g_bad_duration
      $error("traffic_intersection_ctrl: every duration must lie in 1..2**TIME_W-1");
    end
  endgenerate

  // The parameter EW_GREEN hides the phase literal, so the phase is package-qualified.
  phase_t            next_phase;
  logic              ew_req;
  logic              ped_pend;
  logic              ped_walk;
  logic              blink;
  logic              timer_zero;
  logic              timer_load;
  logic [TIME_W-1:0] load_val;
  logic              illegal;
  logic              step;
  logic              enter_ew;
  logic              leave_ew;
  logic              enter_flash;

  assign illegal = (phase > FLASH);
  assign step    = en | illegal;

  always_comb begin
    next_phase = phase;
    case (phase)
      NS_GREEN:
        if (timer_zero && (ew_req || ped_pend || flash_mode)) next_phase = NS_YELLOW;
      NS_YELLOW:
        if (timer_zero) next_phase = ALLRED_A;
      ALLRED_A:
        if (timer_zero) next_phase = flash_mode ? FLASH : traffic_pkg::EW_GREEN;
      traffic_pkg::EW_GREEN:
        if (timer_zero) next_phase = EW_YELLOW;
      EW_YELLOW:
        if (timer_zero) next_phase = ALLRED_B;
      ALLRED_B:
        if (timer_zero) next_phase = flash_mode ? FLASH : NS_GREEN;
      FLASH:
        if (!flash_mode) next_phase = ALLRED_B;
      default:
        next_phase = ALLRED_B;
    endcase
  end

  // A FLASH half-period expiring reloads the timer without changing phase.
  assign timer_load  = step & ((next_phase != phase) | ((phase == FLASH) & timer_zero));
  assign load_val    = TIME_W'(phase_duration(next_phase, NS_MIN_GREEN, EW_GREEN,
                                              YELLOW_TIME, ALLRED_TIME, FLASH_HALF) - 1);
  assign enter_ew    = step & (next_phase == traffic_pkg::EW_GREEN) & (phase != traffic_pkg::EW_GREEN);
  assign leave_ew    = step & (phase == traffic_pkg::EW_GREEN) & (next_phase != traffic_pkg::EW_GREEN);
  assign enter_flash = step & (next_phase == FLASH) & (phase != FLASH);

  phase_timer #(
    .TIME_W    (TIME_W),
    .RESET_VAL (TIME_W'(ALLRED_TIME - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (timer_load),
    .load_val (load_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= ALLRED_B;
      ew_req   <= 1'b0;
      ped_pend <= 1'b0;
      ped_walk <= 1'b0;
      blink    <= 1'b0;
    end else begin
      if (step) phase <= next_phase;
      ew_req   <= ew_sensor | (ew_req & ~enter_ew);
      ped_pend <= ped_req | (ped_pend & ~enter_ew);
      if (enter_ew)      ped_walk <= ped_pend;
      else if (leave_ew) ped_walk <= 1'b0;
      if (enter_flash) begin
        blink <= 1'b1;
      end else if (en && (phase == FLASH) && timer_zero && flash_mode) begin
        blink <= ~blink;
      end
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    case (phase)
      NS_GREEN:              ns_light = GREEN;
      NS_YELLOW:             ns_light = YELLOW;
      traffic_pkg::EW_GREEN: ew_light = GREEN;
      EW_YELLOW:             ew_light = YELLOW;
      FLASH: begin
        ns_light = blink ? YELLOW : OFF;
        ew_light = blink ? RED : OFF;
      end
      default: ;
    endcase
  end

  assign walk = (phase == traffic_pkg::EW_GREEN) & ped_walk;

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// tb_traffic_intersection_ctrl : directed scenarios checked against a
// phase/elapsed-time reference model plus hand-computed phase run lengths.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int NS_MIN = 8;
  localparam int EW_G   = 5;
  localparam int YEL    = 2;
  localparam int AR     = 1;
  localparam int FH     = 3;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   en = 1'b0;
  logic   ew_sensor = 1'b0;
  logic   ped_req = 1'b0;
  logic   flash_mode = 1'b0;
  light_t ns_light;
  light_t ew_light;
  logic   walk;
  phase_t phase;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .TIME_W(8), .NS_MIN_GREEN(NS_MIN), .EW_GREEN(EW_G),
    .YELLOW_TIME(YEL), .ALLRED_TIME(AR), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .flash_mode(flash_mode), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .phase(phase)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase codes follow the listed order NS_GREEN=0 .. FLASH=6.
  int m_phase = 5;
  int m_elapsed = 0;
  int m_nxt;
  bit m_done;
  bit m_ew_req = 0, m_ped_pend = 0, m_ped_walk = 0;

  function automatic int dur(input int p);
    case (p)
      0:       return NS_MIN;
      1, 4:    return YEL;
      3:       return EW_G;
      6:       return FH;
      default: return AR;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 5; m_elapsed = 0;
      m_ew_req = 0; m_ped_pend = 0; m_ped_walk = 0;
    end else begin
      m_nxt = m_phase;
      if (en) begin
        m_done = (m_elapsed + 1 >= dur(m_phase));
        case (m_phase)
          0: if (m_done && (m_ew_req || m_ped_pend || flash_mode)) m_nxt = 1;
          1: if (m_done) m_nxt = 2;
          2: if (m_done) m_nxt = flash_mode ? 6 : 3;
          3: if (m_done) m_nxt = 4;
          4: if (m_done) m_nxt = 5;
          5: if (m_done) m_nxt = flash_mode ? 6 : 0;
          6: if (!flash_mode) m_nxt = 5;
          default: m_nxt = 5;
        endcase
      end
      if (m_nxt == 3 && m_phase != 3) begin
        m_ped_walk = m_ped_pend; m_ped_pend = 0; m_ew_req = 0;
      end
      if (m_phase == 3 && m_nxt != 3) m_ped_walk = 0;
      if (m_nxt != m_phase) m_elapsed = 0;
      else if (en) m_elapsed++;
      m_phase = m_nxt;
      if (ew_sensor) m_ew_req = 1;
      if (ped_req) m_ped_pend = 1;
    end
  end

  logic [1:0] e_ns, e_ew;
  logic       e_walk;
  bit         rec = 0;
  int         tr_phase[$], tr_ns[$], tr_ew[$], tr_walk[$];

  always @(negedge clk) begin
    if (!reset) begin
      e_ns = RED; e_ew = RED;
      case (m_phase)
        0: e_ns = GREEN;
        1: e_ns = YELLOW;
        3: e_ew = GREEN;
        4: e_ew = YELLOW;
        6: begin
          e_ns = (((m_elapsed / FH) % 2) == 0) ? YELLOW : OFF;
          e_ew = (((m_elapsed / FH) % 2) == 0) ? RED : OFF;
        end
        default: ;
      endcase
      e_walk = (m_phase == 3) && m_ped_walk;
      tests++;
      if (phase !== 3'(m_phase) || ns_light !== e_ns || ew_light !== e_ew || walk !== e_walk) begin
        fails++;
        $display("FAIL model t=%0t: got phase=%0d ns=%0d ew=%0d walk=%0b, want phase=%0d ns=%0d ew=%0d walk=%0b",
                 $time, phase, ns_light, ew_light, walk, m_phase, e_ns, e_ew, e_walk);
      end
      tests++;
      if ((phase != FLASH && ns_light != RED && ew_light != RED) || (walk && ew_light != GREEN)) begin
        fails++;
        $display("FAIL safety t=%0t: got phase=%0d ns=%0d ew=%0d walk=%0b, want no conflicting lamps",
                 $time, phase, ns_light, ew_light, walk);
      end
      if (rec) begin
        tr_phase.push_back(int'(phase));
        tr_ns.push_back(int'(ns_light));
        tr_ew.push_back(int'(ew_light));
        tr_walk.push_back(int'(walk));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic start_rec();
    tr_phase.delete(); tr_ns.delete(); tr_ew.delete(); tr_walk.delete();
    rec = 1;
  endtask

  task automatic do_reset();
    reset = 1; en = 1; ew_sensor = 0; ped_req = 0; flash_mode = 0;
    tick();
    tick();
  endtask

  int exp_p[$], exp_l[$], pat_ns[$], pat_ew[$];

  task automatic check_runs(input string name, input int ep[$], input int el[$]);
    int idx;
    idx = 0;
    for (int r = 0; r < ep.size(); r++) begin
      int len;
      len = 0;
      while (idx < tr_phase.size() && tr_phase[idx] == ep[r]) begin
        len++; idx++;
      end
      tests++;
      if (len != el[r]) begin
        fails++;
        $display("FAIL %s run%0d phase%0d: got %0d cycles, want %0d", name, r, ep[r], len, el[r]);
      end
    end
    tests++;
    if (idx != tr_phase.size()) begin
      fails++;
      $display("FAIL %s tail: got %0d unmatched cycles, want 0", name, tr_phase.size() - idx);
    end
  endtask

  function automatic int count_of(input int q[$], input int v);
    int n;
    n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle NS rest
    do_reset();
    @(negedge clk); #1;
    chk("reset_ns", ns_light, RED);
    chk("reset_ew", ew_light, RED);
    chk("reset_walk", walk, 0);
    chk("reset_phase", phase, 5);
    tick();
    reset = 0; start_rec();
    repeat (51) tick();
    rec = 0;
    exp_p = '{5, 0}; exp_l = '{1, 50};
    check_runs("idle", exp_p, exp_l);

    // Vehicle sensor pulse at NS_GREEN cycle 3
    do_reset();
    reset = 0; start_rec();
    repeat (3) tick();
    ew_sensor = 1; tick(); ew_sensor = 0;
    repeat (28) tick();
    rec = 0;
    exp_p = '{5, 0, 1, 2, 3, 4, 5, 0}; exp_l = '{1, 8, 2, 1, 5, 2, 1, 12};
    check_runs("sensor", exp_p, exp_l);

    // Pedestrian request, then a second one during EW_GREEN
    do_reset();
    reset = 0; start_rec();
    tick();
    ped_req = 1; tick(); ped_req = 0;
    repeat (11) tick();
    ped_req = 1; tick(); ped_req = 0;
    repeat (30) tick();
    rec = 0;
    exp_p = '{5, 0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    exp_l = '{1, 8, 2, 1, 5, 2, 1, 8, 2, 1, 5, 2, 1, 5};
    check_runs("ped", exp_p, exp_l);
    chk("ped_walk_total", count_of(tr_walk, 1), 10);
    chk("ped_walk_first_ew", tr_walk[12], 1);
    chk("ped_walk_after_ew", tr_walk[17], 0);

    // Enable held low mid NS_YELLOW; sensor latched while disabled
    do_reset();
    reset = 0; start_rec();
    tick();
    ped_req = 1; tick(); ped_req = 0;
    repeat (7) tick();
    en = 0; repeat (4) tick(); en = 1;
    repeat (12) tick();
    rec = 0;
    exp_p = '{5, 0, 1, 2, 3, 4, 5, 0}; exp_l = '{1, 8, 6, 1, 5, 2, 1, 1};
    check_runs("freeze", exp_p, exp_l);
    chk("freeze_yellow_cycles", count_of(tr_ns, YELLOW), 6);
    repeat (10) tick();
    en = 0; ew_sensor = 1; tick(); ew_sensor = 0; tick();
    @(negedge clk); #1;
    chk("disabled_hold_phase", phase, 0);
    en = 1; tick();
    @(negedge clk); #1;
    chk("disabled_sensor_latched", phase, 1);

    // Flash requested during EW_GREEN, then released
    do_reset();
    reset = 0; start_rec();
    tick();
    ew_sensor = 1; tick(); ew_sensor = 0;
    repeat (11) tick();
    flash_mode = 1;
    repeat (19) tick();
    flash_mode = 0;
    repeat (4) tick();
    rec = 0;
    exp_p = '{5, 0, 1, 2, 3, 4, 5, 6, 5, 0}; exp_l = '{1, 8, 2, 1, 5, 2, 1, 13, 1, 2};
    check_runs("flash", exp_p, exp_l);
    pat_ns = '{1, 1, 1, 3, 3, 3, 1, 1, 1, 3, 3, 3};
    pat_ew = '{2, 2, 2, 3, 3, 3, 2, 2, 2, 3, 3, 3};
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("flash_ns[%0d]", i), tr_ns[20 + i], pat_ns[i]);
      chk($sformatf("flash_ew[%0d]", i), tr_ew[20 + i], pat_ew[i]);
    end

    // Asynchronous reset mid EW_GREEN with walk lit and requests pending
    do_reset();
    reset = 0;
    tick();
    ped_req = 1; tick(); ped_req = 0;
    repeat (10) tick();
    ew_sensor = 1; ped_req = 1; tick(); ew_sensor = 0; ped_req = 0;
    @(negedge clk); #1;
    chk("pre_reset_walk", walk, 1);
    chk("pre_reset_phase", phase, 3);
    reset = 1;
    #1;
    chk("async_reset_ns", ns_light, RED);
    chk("async_reset_ew", ew_light, RED);
    chk("async_reset_walk", walk, 0);
    chk("async_reset_phase", phase, 5);
    tick(); tick();
    reset = 0; start_rec();
    repeat (12) tick();
    rec = 0;
    exp_p = '{5, 0}; exp_l = '{1, 11};
    check_runs("post_reset", exp_p, exp_l);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
